// File: rtl/dram_stb_pkg.sv
// Shared defaults and entry layout for the DRAM store buffer.
// Optional feature macro: DRAM_STB_COALESCE_EN (same-address merge into youngest entry).
package dram_stb_pkg;

  localparam int unsigned STB_DATA_W = 32;
  localparam int unsigned STB_ADDR_W = 32;
  localparam int unsigned STB_DEPTH  = 4;

  // One buffered store at the default geometry.
  typedef struct packed {
    logic [STB_ADDR_W-1:0] adr;
    logic [STB_DATA_W-1:0] data;
  } stb_entry_t;

endpackage

// File: rtl/dram_stb_match.sv
// Youngest-match select for store-to-load forwarding.
// The slot just behind the tail is checked first as a fast path; otherwise
// slots are scanned oldest to youngest from the head so the last hit wins.
module dram_stb_match #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] adr_i  [DEPTH],
  input  logic [DATA_W-1:0] data_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PTR_W-1:0]  head_i,
  input  logic [PTR_W-1:0]  tail_i,
  input  logic [ADDR_W-1:0] ld_adr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] yng_idx;
  logic [PTR_W-1:0] scan_idx;

  // Pick the data of the youngest valid entry whose address matches the load.
  always_comb begin
    hit_o    = 1'b0;
    data_o   = '0;
    scan_idx = '0;
    yng_idx  = tail_i - PTR_W'(1);
    if (valid_i[yng_idx] && (adr_i[yng_idx] == ld_adr_i)) begin
      hit_o  = 1'b1;
      data_o = data_i[yng_idx];
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        scan_idx = head_i + PTR_W'(k);
        if (valid_i[scan_idx] && (adr_i[scan_idx] == ld_adr_i)) begin
          hit_o  = 1'b1;
          data_o = data_i[scan_idx];
        end
      end
    end
  end

endmodule

// File: rtl/dram_store_buffer.sv
// FIFO store buffer in front of DRAM with combinational load forwarding.
// Drains the oldest entry whenever non-empty; mem_ack pops it.
// Optional macro DRAM_STB_COALESCE_EN: a store to the youngest entry's address
// merges into that entry instead of allocating (unless it is the head being popped).
module dram_store_buffer
  import dram_stb_pkg::*;
#(
  parameter int unsigned DATA_W = STB_DATA_W,
  parameter int unsigned ADDR_W = STB_ADDR_W,
  parameter int unsigned DEPTH  = STB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_adr,
  input  logic [DATA_W-1:0] st_wdin,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] rd_,
  output logic              ld_hit,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdin,
  input  logic              mem_ack
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] adr_q  [DEPTH];
  logic [ADDR_W-1:0] adr_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic             full;
  logic             pop;
  logic             accept;
  logic             alloc;
  logic             coalesce;
  logic             coalesce_ok;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] age;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign mem_we = (count_q != '0);
  assign pop    = mem_we && mem_ack;

`ifdef DRAM_STB_COALESCE_EN
  logic [PTR_W-1:0] yng_idx;

  // Merge is allowed into the youngest entry unless it is the sole entry leaving this cycle.
  always_comb begin
    yng_idx     = tail_q - PTR_W'(1);
    coalesce_ok = mem_we && (adr_q[yng_idx] == st_adr) &&
                  !((count_q == CNT_W'(1)) && pop);
  end

  assign st_ready = !full || coalesce_ok;
`else
  assign coalesce_ok = 1'b0;
  assign st_ready    = !full;
`endif

  // Accept/allocate decision and next-state pointers and occupancy.
  always_comb begin
    accept   = st_valid && st_ready;
    coalesce = accept && coalesce_ok;
    alloc    = accept && !coalesce_ok;
    head_d   = pop   ? head_q + PTR_W'(1) : head_q;
    tail_d   = alloc ? tail_q + PTR_W'(1) : tail_q;
    count_d  = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  // Entry storage next-state: allocate at the tail, or merge into the youngest.
  always_comb begin
    adr_d  = adr_q;
    data_d = data_q;
    if (alloc) begin
      adr_d[tail_q]  = st_adr;
      data_d[tail_q] = st_wdin;
    end
`ifdef DRAM_STB_COALESCE_EN
    if (coalesce) begin
      data_d[yng_idx] = st_wdin;
    end
`endif
  end

  // Per-slot valid mask: a slot is live when its distance from the head is below count.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(i) - head_q;
      valid[i] = ({1'b0, age} < count_q);
    end
  end

  dram_stb_match #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_match (
    .adr_i    (adr_q),
    .data_i   (data_q),
    .valid_i  (valid),
    .head_i   (head_q),
    .tail_i   (tail_q),
    .ld_adr_i (ld_adr),
    .hit_o    (fwd_hit),
    .data_o   (fwd_data)
  );

  assign ld_hit   = fwd_hit;
  assign rd_      = fwd_hit ? fwd_data : rd;
  assign mem_adr  = adr_q[head_q];
  assign mem_wdin = data_q[head_q];

  // Control state; reset empties the buffer so nothing drains afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload; contents are qualified by the valid mask so no reset is needed.
  always_ff @(posedge clk) begin
    adr_q  <= adr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dram_store_buffer.sv
// Scoreboard bench for dram_store_buffer: a queue of pending stores is the
// reference; the driver checks combinational outputs, a monitor checks drains.
module tb_dram_store_buffer;
  import dram_stb_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_adr = '0;
  logic [DW-1:0] st_wdin = '0;
  logic [AW-1:0] ld_adr = '0;
  logic [DW-1:0] rd = '0;
  logic [DW-1:0] rd_;
  logic          ld_hit;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdin;
  logic          mem_ack = 1'b0;

  stb_entry_t q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  dram_store_buffer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_adr   (st_adr),
    .st_wdin  (st_wdin),
    .ld_adr   (ld_adr),
    .rd       (rd),
    .rd_      (rd_),
    .ld_hit   (ld_hit),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_wdin (mem_wdin),
    .mem_ack  (mem_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, check outputs, then
  // update the reference queue with what the next rising edge should do.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] la, input logic [31:0] r, input logic ack);
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic        is_full;
    logic        coal;
    logic        exp_ready;
    @(negedge clk);
    st_valid = v; st_adr = a; st_wdin = d; ld_adr = la; rd = r; mem_ack = ack;
    #1;
    exp_hit = 1'b0;
    exp_rd  = r;
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].adr == la) begin
        exp_hit = 1'b1;
        exp_rd  = q[i].data;
        break;
      end
    end
    is_full = (q.size() == DEPTH);
    coal    = 1'b0;
`ifdef DRAM_STB_COALESCE_EN
    if (q.size() != 0 && q[q.size()-1].adr == a && !(q.size() == 1 && ack))
      coal = 1'b1;
`endif
    exp_ready = !is_full || coal;
    chk("st_ready", {31'b0, st_ready}, {31'b0, exp_ready});
    chk("mem_we", {31'b0, mem_we}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("head_adr", mem_adr, q[0].adr);
      chk("head_data", mem_wdin, q[0].data);
    end
    chk("ld_hit", {31'b0, ld_hit}, {31'b0, exp_hit});
    chk("rd_fwd", rd_, exp_rd);
    if (v && exp_ready) begin
      if (coal) q[q.size()-1].data = d;
      else      q.push_back('{adr: a, data: d});
    end
  endtask

  // Assert reset mid-operation and check the outputs react without a clock edge.
  task automatic do_reset(input int unsigned cyc, input logic [31:0] la);
    @(negedge clk);
    rst_n = 1'b0; st_valid = 1'b0; mem_ack = 1'b1; ld_adr = la; rd = $urandom;
    #1;
    q.delete();
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
    chk("rst_rd", rd_, rd);
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_adr();
    return 32'h100 + 32'($urandom_range(0, 5)) * 4;
  endfunction

  // Drain monitor: whenever the DUT issues a write that is acknowledged,
  // it must be the oldest outstanding store.
  initial begin : monitor
    stb_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && mem_we && mem_ack) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL drain_extra: got adr 0x%0h data 0x%0h expected no drain", mem_adr, mem_wdin);
        end else begin
          e = q.pop_front();
          chk("drain_adr", mem_adr, e.adr);
          chk("drain_data", mem_wdin, e.data);
        end
      end
    end
  end

  initial begin : driver
    do_reset(2, 32'h10);

    // Basic forward of a fresh store and drain of it.
    step(1'b1, 32'h10, 32'hAAAA, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h10, 32'h1234, 1'b0);
    chk("fwd_first_hit", {31'b0, ld_hit}, 32'd1);
    chk("fwd_first_rd", rd_, 32'hAAAA);
    chk("fwd_first_madr", mem_adr, 32'h10);
    repeat (2) step(1'b0, 32'h0, 32'h0, 32'h10, 32'h1234, 1'b1);
    chk("fwd_after_drain", rd_, 32'h1234);

    // Youngest of two same-address stores wins; drain keeps program order.
    step(1'b1, 32'h20, 32'd1, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h24, 32'd2, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h20, 32'd3, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h20, 32'h5555, 1'b0);
    chk("youngest_rd", rd_, 32'd3);
    repeat (4) step(1'b0, 32'h0, 32'h0, 32'h20, 32'h5555, 1'b1);

    // Full buffer back-pressure; a pop while full does not let a store in.
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 32'h40 + 32'(i) * 4, 32'h100 + 32'(i), 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h80, 32'hBEEF, 32'h80, 32'h7, 1'b0);
    chk("full_ready", {31'b0, st_ready}, 32'd0);
    step(1'b1, 32'h80, 32'hBEEF, 32'h80, 32'h7, 1'b1);
    step(1'b1, 32'h80, 32'hBEEF, 32'h80, 32'h7, 1'b0);
    chk("ready_after_pop", {31'b0, st_ready}, 32'd1);
    repeat (DEPTH + 1) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Simultaneous accept and pop at count 2, repeated to wrap the pointers.
    step(1'b1, 32'h60, 32'd10, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h64, 32'd11, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3 * int'(DEPTH); i++)
      step(1'b1, 32'h68 + 32'(i) * 4, 32'd12 + 32'(i), 32'h68 + 32'(i) * 4, 32'h0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Same address twice without drain: merges or allocates depending on the build.
    step(1'b1, 32'h30, 32'd5, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h30, 32'd6, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h30, 32'h0, 1'b0);
    chk("same_adr_rd", rd_, 32'd6);
    repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Reset with pending stores discards them.
    step(1'b1, 32'h50, 32'd1, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h54, 32'd2, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h58, 32'd3, 32'h0, 32'h0, 1'b0);
    do_reset(2, 32'h54);
    repeat (3) step(1'b0, 32'h0, 32'h0, 32'h54, 32'h99, 1'b1);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset($urandom_range(1, 2), pick_adr());
      else
        step($urandom_range(0, 9) < 7, pick_adr(), $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom : pick_adr(),
             $urandom, $urandom_range(0, 9) < 4);
    end

    repeat (DEPTH + 2) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    #3;
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_store_buffer.md
DRAM_STORE_BUFFER -- requirements
Module: dram_store_buffer

Interface
REQ-001 Parameter DATA_W, default 32, data width of stores and reads.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DEPTH, default 4, number of buffered stores; power of two, >= 2.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset, with ports as follows.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 st_valid  in  1  store request.
REQ-008 st_ready  out  1  buffer can accept a store.
REQ-009 st_adr  in  ADDR_W  store address.
REQ-010 st_wdin  in  DATA_W  store data.
REQ-011 ld_adr  in  ADDR_W  load address under lookup.
REQ-012 rd  in  DATA_W  data returned by DRAM for ld_adr.
REQ-013 rd_  out  DATA_W  load data after forwarding.
REQ-014 ld_hit  out  1  rd_ sourced from the buffer.
REQ-015 mem_we  out  1  drain write request to DRAM.
REQ-016 mem_adr  out  ADDR_W  drain address (oldest entry).
REQ-017 mem_wdin  out  DATA_W  drain data (oldest entry).
REQ-018 mem_ack  in  1  DRAM accepted the drain write this cycle.

Function
REQ-019 The buffer SHALL be a FIFO of DEPTH {adr, data} entries with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-020 st_ready SHALL equal (count != DEPTH), derived from registered state only.
REQ-021 A store SHALL be accepted when st_valid && st_ready; it is written at the tail and is visible from the next cycle.
REQ-022 mem_we SHALL equal (count != 0); mem_adr/mem_wdin SHALL present the head entry combinationally.
REQ-023 On mem_we && mem_ack, the head SHALL be popped at the clock edge; mem_ack while mem_we is low SHALL be ignored.
REQ-024 Simultaneous accept and pop SHALL leave count unchanged and advance both pointers.
REQ-025 When full, no store is accepted even if a pop occurs in the same cycle.
REQ-026 Forwarding SHALL be combinational: ld_hit = any valid entry with adr == ld_adr; rd_ = data of the youngest matching entry, else rd.
REQ-027 A store being accepted in the current cycle SHALL NOT be forwarded in that cycle; an entry being popped in the current cycle SHALL still be forwarded in that cycle.
REQ-028 Write data SHALL be stored full-width; no partial writes.

Reset
REQ-029 While rst_n is low: count=0, head=tail=0, st_ready=1, mem_we=0, ld_hit=0, rd_=rd; entry storage need not be cleared.
REQ-030 A reset asserted mid-operation SHALL discard all buffered stores without issuing drain writes.

Configuration
REQ-031 With macro DRAM_STB_COALESCE_EN defined, an accepted store whose st_adr equals the youngest valid entry's address SHALL overwrite that entry's data without allocating, unless that entry is the head and is being popped this cycle, in which case it allocates normally.
REQ-032 With DRAM_STB_COALESCE_EN defined, st_ready SHALL also be 1 when full and st_adr matches the youngest entry, provided that entry is not being popped this cycle.
REQ-033 Without the macro, every accepted store SHALL allocate a new entry and REQ-020 holds unchanged.

Structure
REQ-034 Package dram_stb_pkg SHALL hold the default widths/depth and the entry typedef {adr, data}.
REQ-035 Sub-module dram_stb_match SHALL perform the youngest-match priority select given the entry array, valid mask and head/tail pointers.

Verification
REQ-036 Reset, then st 0x10<-0xAAAA, mem_ack=0; next cycle ld_adr=0x10, rd=0x1234 -> ld_hit=1, rd_=0xAAAA, mem_we=1, mem_adr=0x10.
REQ-037 Stores 0x20<-1, 0x24<-2, 0x20<-3 (macro off), ld_adr=0x20 -> rd_=3; drain order 0x20/1, 0x24/2, 0x20/3.
REQ-038 Fill DEPTH=4 with mem_ack=0 -> st_ready=0 and a 5th store is held; one mem_ack -> st_ready=1 next cycle.
REQ-039 Store and mem_ack in the same cycle at count=2 -> count stays 2; pointers wrap correctly across 3 full cycles of traffic.
REQ-040 Macro on: stores 0x30<-5 then 0x30<-6 with mem_ack=0 -> count=1, drain writes 0x30/6 once.
REQ-041 rst_n low with 3 entries pending -> mem_we=0 immediately, ld_hit=0, rd_=rd; no drain after release.
